// File: rtl/sipo_frame_rx.sv
// ============================================================================
// Module  : sipo_frame_rx
// Brief   : Start-bit framed serial-to-parallel receiver, MSB-first, with a
//           registered valid/ready output and sticky overrun flag.
//           Optional even-parity bit when SIPO_PARITY_EN is defined.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module sipo_frame_rx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             serial_in,
  input  logic             out_ready,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             overrun,
  output logic             parity_err,
  output logic             busy
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

`ifdef SIPO_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1
  } state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;

  logic [WIDTH-1:0] shifted;
  logic             commit;
  logic [WIDTH-1:0] commit_word;
`ifdef SIPO_PARITY_EN
  logic             commit_perr;
`endif

  assign shifted = {shreg[WIDTH-2:0], serial_in};

  // The committed word must include the bit sampled on the commit edge itself.
  always_comb begin
    commit      = 1'b0;
    commit_word = shifted;
`ifdef SIPO_PARITY_EN
    commit_perr = 1'b0;
`endif
    if (bit_en) begin
      case (state)
`ifdef SIPO_PARITY_EN
        PARITY: begin
          commit      = 1'b1;
          commit_word = shreg;
          commit_perr = (^shreg) ^ serial_in;
        end
`else
        DATA: begin
          commit = (bit_cnt == LAST);
        end
`endif
        default: begin
          commit = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      busy      <= 1'b0;
      data_out  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (bit_en) begin
        case (state)
          IDLE: begin
            if (serial_in) begin
              state   <= DATA;
              bit_cnt <= '0;
              busy    <= 1'b1;
            end
          end
          DATA: begin
            shreg <= shifted;
            if (bit_cnt == LAST) begin
`ifdef SIPO_PARITY_EN
              state <= PARITY;
`else
              state <= IDLE;
              busy  <= 1'b0;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end

      // A commit on an accepting edge replaces the word without overrun.
      if (commit) begin
        data_out  <= commit_word;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (commit && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef SIPO_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_err <= 1'b0;
    end else if (commit) begin
      parity_err <= commit_perr;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sipo_frame_rx.sv
// ============================================================================
// Module  : tb_sipo_frame_rx
// Brief   : Directed self-checking bench for sipo_frame_rx (WIDTH=4),
//           expected words kept in a scoreboard queue.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_sipo_frame_rx;

`ifdef SIPO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_en;
  logic       serial_in;
  logic       out_ready;
  logic       ovr_clr;
  logic [3:0] data_out;
  logic       out_valid;
  logic       overrun;
  logic       parity_err;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_q[$];
  logic [3:0] dropped;

  sipo_frame_rx #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_en    (bit_en),
    .serial_in (serial_in),
    .out_ready (out_ready),
    .ovr_clr   (ovr_clr),
    .data_out  (data_out),
    .out_valid (out_valid),
    .overrun   (overrun),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%b expected=<empty scoreboard>", tag, data_out);
    end else begin
      e = exp_q.pop_front();
      chkw(tag, data_out, e);
    end
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    bit_en    = 1'b1;
    tick();
  endtask

  // Full frame with bit_en held high; vexp is the out_valid level expected
  // on every pre-commit edge.
  task automatic frame(input logic [3:0] w, input logic pbit, input logic vexp);
    logic perr_exp;
    perr_exp = PAR ? ((^w) ^ pbit) : 1'b0;
    send_bit(1'b1);
    chk1("busy_after_start", busy, 1'b1);
    chk1("valid_after_start", out_valid, vexp);
    for (int i = 3; i >= 0; i--) begin
      send_bit(w[i]);
      if (i > 0 || PAR) begin
        chk1("busy_mid_frame", busy, 1'b1);
        chk1("valid_mid_frame", out_valid, vexp);
      end
    end
    if (PAR) send_bit(pbit);
    bit_en    = 1'b0;
    serial_in = 1'b0;
    chk1("busy_after_commit", busy, 1'b0);
    chk1("valid_after_commit", out_valid, 1'b1);
    chk1("parity_err", parity_err, perr_exp);
  endtask

  initial begin
    logic [5:0] fb;
    int         nb;

    rst       = 1'b1;
    bit_en    = 1'b0;
    serial_in = 1'b0;
    out_ready = 1'b0;
    ovr_clr   = 1'b0;
    #1 rst    = 1'b0;
    tick();
    tick();
    chkw("reset_data", data_out, 4'b0000);
    chk1("reset_valid", out_valid, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_overrun", overrun, 1'b0);
    chk1("reset_perr", parity_err, 1'b0);
    rst = 1'b1;
    tick();

    // Idle line: no start bit, nothing happens
    bit_en = 1'b1;
    serial_in = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_valid", out_valid, 1'b0);
    chkw("idle_data", data_out, 4'b0000);
    bit_en = 1'b0;

    // Single frame 1011, ready low
    exp_q.push_back(4'b1011);
    frame(4'b1011, ^4'b1011, 1'b0);
    pop_chk("frame1_data");
    chk1("frame1_overrun", overrun, 1'b0);
    tick();
    chk1("frame1_valid_held", out_valid, 1'b1);
    out_ready = 1'b1;
    tick();
    chk1("frame1_accepted", out_valid, 1'b0);
    out_ready = 1'b0;

    // Back-to-back, ready low -> overrun
    exp_q.push_back(4'b1011);
    exp_q.push_back(4'b0110);
    frame(4'b1011, ^4'b1011, 1'b0);
    chk1("b2b_first_overrun", overrun, 1'b0);
    frame(4'b0110, ^4'b0110, 1'b1);
    chk1("b2b_overrun_set", overrun, 1'b1);
    dropped = exp_q.pop_front();  // overwritten before acceptance
    pop_chk("b2b_second_data");
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk1("ovr_clr", overrun, 1'b0);
    chk1("ovr_clr_valid_kept", out_valid, 1'b1);
    out_ready = 1'b1;
    tick();
    chk1("b2b_drain", out_valid, 1'b0);

    // Back-to-back with ready held: first word accepted on the next start edge
    exp_q.push_back(4'b1011);
    exp_q.push_back(4'b0110);
    frame(4'b1011, ^4'b1011, 1'b0);
    pop_chk("rdy_first_data");
    frame(4'b0110, ^4'b0110, 1'b0);
    pop_chk("rdy_second_data");
    chk1("rdy_no_overrun", overrun, 1'b0);
    tick();
    chk1("rdy_second_accepted", out_valid, 1'b0);
    out_ready = 1'b0;

    // bit_en toggling 1,0,1,0 during frame 1011
    exp_q.push_back(4'b1011);
    fb = {1'b1, 4'b1011, ^4'b1011};
    nb = PAR ? 6 : 5;
    for (int k = 0; k < nb; k++) begin
      send_bit(fb[5-k]);
      if (k < nb - 1) begin
        chk1("toggle_busy_en", busy, 1'b1);
        chk1("toggle_valid_en", out_valid, 1'b0);
        bit_en = 1'b0;
        tick();
        chk1("toggle_busy_frozen", busy, 1'b1);
        chk1("toggle_valid_frozen", out_valid, 1'b0);
      end
    end
    bit_en    = 1'b0;
    serial_in = 1'b0;
    chk1("toggle_valid_commit", out_valid, 1'b1);
    chk1("toggle_busy_done", busy, 1'b0);
    pop_chk("toggle_data");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset after two data bits, then a clean frame 0101
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    chk1("pre_reset_busy", busy, 1'b1);
    rst = 1'b0;
    #2;
    chk1("async_reset_busy", busy, 1'b0);
    chk1("async_reset_valid", out_valid, 1'b0);
    chkw("async_reset_data", data_out, 4'b0000);
    bit_en = 1'b0;
    serial_in = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk1("post_reset_valid", out_valid, 1'b0);
    exp_q.push_back(4'b0101);
    frame(4'b0101, ^4'b0101, 1'b0);
    pop_chk("post_reset_data");
    chk1("post_reset_overrun", overrun, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

`ifdef SIPO_PARITY_EN
    exp_q.push_back(4'b1011);
    frame(4'b1011, 1'b1, 1'b0);
    pop_chk("par_good_data");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_q.push_back(4'b1011);
    frame(4'b1011, 1'b0, 1'b0);
    pop_chk("par_bad_data");
`endif

    chk1("scoreboard_empty", exp_q.size() == 0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
